// File: rtl/adc_config_rx_pkg.sv
// Shared definitions for the ADC configuration link: receiver state encoding and
// the frame geometry also used by the configuration transmitter.
package adc_config_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int         FRAME_BITS_DEF = 24;
    localparam int         ADDR_W         = 5;
    localparam logic [4:0] LAST_ADDR_DEF  = 5'h10;
    localparam logic [3:0] ERR_CNT_MAX    = 4'hF;

endpackage

// File: rtl/adc_config_rx_tmr_vote3.sv
// Bitwise 2-of-3 majority voter used to recover triplicated registers.
module tmr_vote3 #(
    parameter int W = 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] y_o
);

    assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/adc_config_rx.sv
// Receiver for the ADC serial-configuration stream: deserialises frames, tags good
// words with a sequential ROM address and counts malformed frames. Control is TMR.
module adc_config_rx
    import adc_config_rx_pkg::*;
#(
    parameter int         FRAME_BITS = FRAME_BITS_DEF,
    parameter logic [4:0] LAST_ADDR  = LAST_ADDR_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SCKEN,
    input  logic                  SHEN,
    input  logic                  LOAD,
    input  logic                  SDIN,
    input  logic                  CLR,
    output logic [FRAME_BITS-1:0] WORD,
    output logic [ADDR_W-1:0]     WADR,
    output logic                  WVALID,
    output logic                  FRAME_ERR,
    output logic [3:0]            ERR_CNT,
    output logic                  RX_DONE
);

    // Bit counter saturates one past a full frame so over-long frames stay distinguishable.
    localparam int                BCNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(FRAME_BITS);
    localparam logic [BCNT_W-1:0] BCNT_SAT  = BCNT_W'(FRAME_BITS + 1);

    state_e                state_q0, state_q1, state_q2, state_v, state_d;
    logic [1:0]            state_vote;
    logic [ADDR_W-1:0]     addr_q0, addr_q1, addr_q2, addr_v, addr_d;
    logic [BCNT_W-1:0]     bcnt_q0, bcnt_q1, bcnt_q2, bcnt_v, bcnt_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d, word_q, word_d;
    logic [ADDR_W-1:0]     wadr_q, wadr_d;
    logic                  wvalid_q, wvalid_d;
    logic                  ferr_q, ferr_d;
    logic [3:0]            ecnt_q, ecnt_d;
    logic                  shift;

    tmr_vote3 #(.W(2)) u_vote_state (
        .a_i(state_q0), .b_i(state_q1), .c_i(state_q2), .y_o(state_vote)
    );
    tmr_vote3 #(.W(ADDR_W)) u_vote_addr (
        .a_i(addr_q0), .b_i(addr_q1), .c_i(addr_q2), .y_o(addr_v)
    );
    tmr_vote3 #(.W(BCNT_W)) u_vote_bcnt (
        .a_i(bcnt_q0), .b_i(bcnt_q1), .c_i(bcnt_q2), .y_o(bcnt_v)
    );

    assign state_v = state_e'(state_vote);
    // The frame closes on any cycle that is not a valid shift cycle.
    assign shift   = SCKEN & SHEN & ~LOAD;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_v;
        addr_d   = addr_v;
        bcnt_d   = bcnt_v;
        sr_d     = sr_q;
        word_d   = word_q;
        wadr_d   = wadr_q;
        wvalid_d = 1'b0;
        ferr_d   = ferr_q;
        ecnt_d   = ecnt_q;

        case (state_v)
            ST_IDLE: begin
                if (shift) begin
                    state_d = ST_SHIFT;
                    sr_d    = {sr_q[FRAME_BITS-2:0], SDIN};
                    bcnt_d  = BCNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (shift) begin
                    if (bcnt_v < BCNT_FULL) sr_d = {sr_q[FRAME_BITS-2:0], SDIN};
                    if (bcnt_v != BCNT_SAT) bcnt_d = bcnt_v + 1'b1;
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                state_d = ST_IDLE;
                if (bcnt_v == BCNT_FULL) begin
                    wvalid_d = 1'b1;
                    word_d   = sr_q;
                    wadr_d   = addr_v;
                    if (addr_v == LAST_ADDR) state_d = ST_DONE;
                    else                     addr_d  = addr_v + 1'b1;
                end else begin
                    ferr_d = 1'b1;
                    if (ecnt_q != ERR_CNT_MAX) ecnt_d = ecnt_q + 1'b1;
                end
                // A shift during EMIT is the first bit of a back-to-back frame.
                if (shift && state_d != ST_DONE) begin
                    state_d = ST_SHIFT;
                    sr_d    = {sr_q[FRAME_BITS-2:0], SDIN};
                    bcnt_d  = BCNT_W'(1);
                end
            end
            ST_DONE: begin
                if (CLR) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (CLR) begin
            ferr_d = 1'b0;
            ecnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all copies update from the same voted values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q0 <= ST_IDLE;
            state_q1 <= ST_IDLE;
            state_q2 <= ST_IDLE;
            addr_q0  <= '0;
            addr_q1  <= '0;
            addr_q2  <= '0;
            bcnt_q0  <= '0;
            bcnt_q1  <= '0;
            bcnt_q2  <= '0;
            sr_q     <= '0;
            word_q   <= '0;
            wadr_q   <= '0;
            wvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            state_q0 <= state_d;
            state_q1 <= state_d;
            state_q2 <= state_d;
            addr_q0  <= addr_d;
            addr_q1  <= addr_d;
            addr_q2  <= addr_d;
            bcnt_q0  <= bcnt_d;
            bcnt_q1  <= bcnt_d;
            bcnt_q2  <= bcnt_d;
            sr_q     <= sr_d;
            word_q   <= word_d;
            wadr_q   <= wadr_d;
            wvalid_q <= wvalid_d;
            ferr_q   <= ferr_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign WORD      = word_q;
    assign WADR      = wadr_q;
    assign WVALID    = wvalid_q;
    assign FRAME_ERR = ferr_q;
    assign ERR_CNT   = ecnt_q;
    assign RX_DONE   = (state_v == ST_DONE);

endmodule

// File: tb/tb_adc_config_rx.sv
// Self-checking bench for adc_config_rx: random frames scored against a frame-level model.
module tb_adc_config_rx;
    import adc_config_rx_pkg::*;

    localparam int FB   = 24;
    localparam int LAST = 16;

    logic          CLK = 1'b0;
    logic          RST, SCKEN, SHEN, LOAD, SDIN, CLR;
    logic [FB-1:0] WORD;
    logic [4:0]    WADR;
    logic          WVALID, FRAME_ERR, RX_DONE;
    logic [3:0]    ERR_CNT;

    adc_config_rx #(.FRAME_BITS(FB), .LAST_ADDR(5'h10)) dut (
        .CLK(CLK), .RST(RST), .SCKEN(SCKEN), .SHEN(SHEN), .LOAD(LOAD), .SDIN(SDIN),
        .CLR(CLR), .WORD(WORD), .WADR(WADR), .WVALID(WVALID), .FRAME_ERR(FRAME_ERR),
        .ERR_CNT(ERR_CNT), .RX_DONE(RX_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]    adr;
        logic [FB-1:0] word;
        int            at;
    } wr_t;

    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;
    wr_t cap_q[$];
    wr_t exp_q[$];

    // Frame-level reference model.
    int m_addr;
    bit m_done;
    bit m_err;
    int m_ecnt;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (WVALID === 1'b1) begin
            wr_t w;
            w.adr  = WADR;
            w.word = WORD;
            w.at   = cyc;
            cap_q.push_back(w);
        end
    end

    function automatic void model_frame(input int n, input logic [63:0] data);
        wr_t w;
        if (m_done) return;
        if (n == FB) begin
            w.adr  = m_addr[4:0];
            w.word = data[FB-1:0];
            w.at   = 0;
            exp_q.push_back(w);
            if (m_addr == LAST) m_done = 1'b1;
            else                m_addr++;
        end else begin
            m_err = 1'b1;
            if (m_ecnt < 15) m_ecnt++;
        end
    endfunction

    function automatic void model_clr();
        if (m_done) begin
            m_done = 1'b0;
            m_addr = 0;
        end
        m_err  = 1'b0;
        m_ecnt = 0;
    endfunction

    task automatic drive(input logic scken, input logic shen, input logic load,
                         input logic sdin, input logic clr);
        @(negedge CLK);
        SCKEN = scken; SHEN = shen; LOAD = load; SDIN = sdin; CLR = clr;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++)
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic send_frame(input int n, input logic [63:0] data, output int load_cyc);
        for (int i = n - 1; i >= 0; i--) drive(1'b1, 1'b1, 1'b0, data[i], 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        load_cyc = cyc;
        model_frame(n, data);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; SCKEN = 1'b0; SHEN = 1'b0; LOAD = 1'b0; SDIN = 1'b0; CLR = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        cap_q.delete();
        exp_q.delete();
        m_addr = 0; m_done = 1'b0; m_err = 1'b0; m_ecnt = 0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({WORD, WADR, WVALID, FRAME_ERR, ERR_CNT, RX_DONE} !== '0) begin
            $display("FAIL reset_outputs: got %h required 0",
                     {WORD, WADR, WVALID, FRAME_ERR, ERR_CNT, RX_DONE});
            miscompares++;
        end
    endtask

    task automatic test_single();
        int lc;
        do_reset();
        send_frame(FB, 64'hA5C3F0, lc);
        gap(5);
        vectors++;
        if (cap_q.size() != 1) begin
            $display("FAIL single_count: got %0d required 1", cap_q.size());
            miscompares++;
        end else begin
            vectors += 3;
            if (cap_q[0].word !== 24'hA5C3F0) begin
                $display("FAIL single_word: got %h required a5c3f0", cap_q[0].word);
                miscompares++;
            end
            if (cap_q[0].adr !== 5'd0) begin
                $display("FAIL single_wadr: got %h required 0", cap_q[0].adr);
                miscompares++;
            end
            if (cap_q[0].at != lc + 2) begin
                $display("FAIL single_latency: got %0d required %0d", cap_q[0].at - lc, 2);
                miscompares++;
            end
        end
        vectors++;
        if (FRAME_ERR !== 1'b0 || RX_DONE !== 1'b0) begin
            $display("FAIL single_flags: got err=%b done=%b required 0 0", FRAME_ERR, RX_DONE);
            miscompares++;
        end
    endtask

    task automatic test_full_sequence();
        int lc;
        logic [63:0] d;
        do_reset();
        for (int f = 0; f <= LAST; f++) begin
            send_frame(FB, rnd64(), lc);
            gap($urandom_range(0, 3));
        end
        gap(4);
        vectors++;
        if (cap_q.size() != exp_q.size()) begin
            $display("FAIL seq_count: got %0d required %0d", cap_q.size(), exp_q.size());
            miscompares++;
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            vectors++;
            if (cap_q[i].adr !== exp_q[i].adr || cap_q[i].word !== exp_q[i].word) begin
                $display("FAIL seq_word%0d: got %h/%h required %h/%h", i,
                         cap_q[i].adr, cap_q[i].word, exp_q[i].adr, exp_q[i].word);
                miscompares++;
            end
        end
        vectors++;
        if (RX_DONE !== m_done) begin
            $display("FAIL seq_done: got %b required %b", RX_DONE, m_done);
            miscompares++;
        end
        send_frame(FB, rnd64(), lc);
        gap(4);
        vectors++;
        if (cap_q.size() != exp_q.size()) begin
            $display("FAIL done_ignores: got %0d words required %0d", cap_q.size(), exp_q.size());
            miscompares++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_clr();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (RX_DONE !== 1'b0) begin
            $display("FAIL clr_leaves_done: got %b required 0", RX_DONE);
            miscompares++;
        end
        d = rnd64();
        send_frame(FB, d, lc);
        gap(4);
        vectors++;
        if (cap_q.size() != exp_q.size() || cap_q[$].adr !== 5'd0 || cap_q[$].word !== d[FB-1:0]) begin
            $display("FAIL clr_restart: got %h/%h required 00/%h", cap_q[$].adr, cap_q[$].word, d[FB-1:0]);
            miscompares++;
        end
    endtask

    task automatic test_short_frame();
        int lc;
        logic [63:0] d;
        do_reset();
        send_frame(FB, rnd64(), lc);
        send_frame(FB - 1, rnd64(), lc);
        gap(4);
        vectors++;
        if (cap_q.size() != 1 || FRAME_ERR !== 1'b1 || ERR_CNT !== 4'd1) begin
            $display("FAIL short_frame: got words=%0d err=%b cnt=%0d required 1 1 1",
                     cap_q.size(), FRAME_ERR, ERR_CNT);
            miscompares++;
        end
        d = rnd64();
        send_frame(FB, d, lc);
        gap(4);
        vectors++;
        if (cap_q.size() != 2 || cap_q[$].adr !== 5'd1 || cap_q[$].word !== d[FB-1:0]) begin
            $display("FAIL short_same_addr: got %h/%h required 01/%h",
                     cap_q[$].adr, cap_q[$].word, d[FB-1:0]);
            miscompares++;
        end
    endtask

    task automatic test_long_and_saturate();
        int lc, n;
        do_reset();
        send_frame(30, rnd64(), lc);
        gap(4);
        vectors++;
        if (cap_q.size() != 0 || FRAME_ERR !== 1'b1 || ERR_CNT !== 4'd1) begin
            $display("FAIL long_frame: got words=%0d err=%b cnt=%0d required 0 1 1",
                     cap_q.size(), FRAME_ERR, ERR_CNT);
            miscompares++;
        end
        for (int f = 0; f < 16; f++) begin
            do n = $urandom_range(1, 40); while (n == FB);
            send_frame(n, rnd64(), lc);
            gap($urandom_range(0, 2));
        end
        gap(4);
        vectors++;
        if (ERR_CNT !== 4'(m_ecnt) || m_ecnt != 15) begin
            $display("FAIL err_saturate: got %0d required %0d", ERR_CNT, m_ecnt);
            miscompares++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_clr();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (FRAME_ERR !== m_err || ERR_CNT !== 4'(m_ecnt)) begin
            $display("FAIL clr_errors: got err=%b cnt=%0d required 0 0", FRAME_ERR, ERR_CNT);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int lc;
        logic [63:0] d;
        do_reset();
        send_frame(FB, rnd64(), lc);
        send_frame(10, rnd64(), lc);
        d = rnd64();
        for (int i = FB - 1; i >= FB - 12; i--) drive(1'b1, 1'b1, 1'b0, d[i], 1'b0);
        do_reset();
        vectors++;
        if ({WORD, WADR, WVALID, FRAME_ERR, ERR_CNT, RX_DONE} !== '0) begin
            $display("FAIL midreset_outputs: got %h required 0",
                     {WORD, WADR, WVALID, FRAME_ERR, ERR_CNT, RX_DONE});
            miscompares++;
        end
        d = rnd64();
        send_frame(FB, d, lc);
        gap(4);
        vectors++;
        if (cap_q.size() != 1 || cap_q[0].adr !== 5'd0 || cap_q[0].word !== d[FB-1:0]) begin
            $display("FAIL midreset_fresh: got %0d words %h/%h required 00/%h",
                     cap_q.size(), cap_q[0].adr, cap_q[0].word, d[FB-1:0]);
            miscompares++;
        end
    endtask

    task automatic test_tmr_upset();
        int lc;
        logic [63:0] d;
        do_reset();
        send_frame(FB, rnd64(), lc);
        d = rnd64();
        for (int i = FB - 1; i >= FB - 10; i--) drive(1'b1, 1'b1, 1'b0, d[i], 1'b0);
        force dut.state_q1 = ST_DONE;
        force dut.addr_q2  = 5'h1F;
        drive(1'b1, 1'b1, 1'b0, d[FB-11], 1'b0);
        release dut.state_q1;
        release dut.addr_q2;
        drive(1'b1, 1'b1, 1'b0, d[FB-12], 1'b0);
        vectors++;
        if (dut.state_q0 !== dut.state_q1 || dut.state_q1 !== dut.state_q2 ||
            dut.addr_q0 !== dut.addr_q2 || dut.addr_q1 !== dut.addr_q2) begin
            $display("FAIL tmr_reagree: got state %0d %0d %0d addr %h %h %h required equal copies",
                     dut.state_q0, dut.state_q1, dut.state_q2, dut.addr_q0, dut.addr_q1, dut.addr_q2);
            miscompares++;
        end
        for (int i = FB - 13; i >= 0; i--) drive(1'b1, 1'b1, 1'b0, d[i], 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        model_frame(FB, d);
        gap(4);
        vectors++;
        if (cap_q.size() != 2 || cap_q[1].adr !== 5'd1 || cap_q[1].word !== d[FB-1:0]) begin
            $display("FAIL tmr_word: got %0d words %h/%h required 01/%h",
                     cap_q.size(), cap_q[1].adr, cap_q[1].word, d[FB-1:0]);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        int lc, n;
        do_reset();
        for (int f = 0; f < 12; f++) begin
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(20, 28) : FB;
            send_frame(n, rnd64(), lc);
        end
        gap(4);
        vectors++;
        if (cap_q.size() != exp_q.size()) begin
            $display("FAIL b2b_count: got %0d required %0d", cap_q.size(), exp_q.size());
            miscompares++;
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            vectors++;
            if (cap_q[i].adr !== exp_q[i].adr || cap_q[i].word !== exp_q[i].word) begin
                $display("FAIL b2b_word%0d: got %h/%h required %h/%h", i,
                         cap_q[i].adr, cap_q[i].word, exp_q[i].adr, exp_q[i].word);
                miscompares++;
            end
        end
        vectors++;
        if (FRAME_ERR !== m_err || ERR_CNT !== 4'(m_ecnt)) begin
            $display("FAIL b2b_errors: got err=%b cnt=%0d required %b %0d",
                     FRAME_ERR, ERR_CNT, m_err, m_ecnt);
            miscompares++;
        end
    endtask

    initial begin
        RST = 1'b1; SCKEN = 1'b0; SHEN = 1'b0; LOAD = 1'b0; SDIN = 1'b0; CLR = 1'b0;
        test_reset();
        test_single();
        test_full_sequence();
        test_short_frame();
        test_long_and_saturate();
        test_reset_mid_frame();
        test_tmr_upset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
